sccb_arbiter: RTL
=================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 The block SHALL have these parameters: N_REQ, default 3, number of requesters; MAX_RETRY, default 2, re-issues after an ack error; TIMEOUT_CYCLES, default 65535, watchdog limit in clk_i cycles.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester level request, held until its done_o bit pulses.
- req_rw_i  in  N_REQ  per-requester op: 1 = read, 0 = write.
- req_data_i  in  16*N_REQ  per-requester {reg_addr, wdata}; requester k uses bits [16k+15:16k].
- start_o  out  1  start to the SCCB controller.
- rw_o  out  1  op to the SCCB controller.
- data_o  out  16  {reg_addr, wdata} to the SCCB controller.
- sccb_done_i  in  1  controller transaction-done level.
- ack_error_i  in  1  controller NACK flag, valid when sccb_done_i rises.
- rdata_i  in  8  controller read data, valid when sccb_done_i rises.
- gnt_o  out  N_REQ  one-hot current owner.
- done_o  out  N_REQ  one-cycle completion pulse per requester.
- err_o  out  1  final-failure flag, valid with done_o.
- rdata_o  out  8  read result, valid with done_o.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, GAP and COMPLETE.
REQ-004 In IDLE with any req_i bit set, the arbiter SHALL grant round-robin, searching from (last_grant+1) mod N_REQ.
REQ-005 At grant, the arbiter SHALL latch rw and data, set gnt_o, clear the retry count and move to ISSUE on the next cycle.
REQ-006 In ISSUE, start_o SHALL go to 1, rw_o and data_o SHALL drive the latched values, and the FSM SHALL move to WAIT on the next cycle.
REQ-007 In WAIT, start_o SHALL stay at 1 until a 0-to-1 edge of sccb_done_i is detected through a registered previous value; start_o SHALL go to 0 in the same cycle the edge is detected.
REQ-008 On a done edge with ack_error_i=0, the FSM SHALL capture rdata_i and go to COMPLETE with err=0.
REQ-009 On a done edge with ack_error_i=1 and retry count < MAX_RETRY, the FSM SHALL increment the retry count and go to GAP.
REQ-010 On a done edge with ack_error_i=1 and retry count = MAX_RETRY, the FSM SHALL go to COMPLETE with err=1 and rdata_o=8'h00.
REQ-011 GAP SHALL last until sccb_done_i is sampled at 1 with start_o at 0, then return to ISSUE; total attempts SHALL equal MAX_RETRY+1.
REQ-012 COMPLETE SHALL last exactly one cycle: done_o[owner] is 1 and err_o/rdata_o are valid; last_grant becomes the owner and gnt_o clears; the FSM returns to IDLE.
REQ-013 A new grant SHALL NOT occur earlier than the cycle after COMPLETE, so back-to-back requests have at least one IDLE cycle between them.
REQ-014 Deassertion of req_i by the owner mid-transaction SHALL be ignored: the transaction completes and done_o still pulses.
REQ-015 New req_i bits asserted during a transaction SHALL wait; grant order SHALL stay round-robin, with no requester starved beyond N_REQ-1 transactions.
REQ-016 rw_o and data_o SHALL stay stable from ISSUE through COMPLETE.
REQ-017 err_o and rdata_o SHALL hold their last values outside COMPLETE.

Reset
REQ-018 Asserting rst_i SHALL immediately force: FSM=IDLE; start_o=0, rw_o=0, data_o=0, gnt_o=0, done_o=0, err_o=0, rdata_o=0, busy_o=0; retry count=0; last_grant=N_REQ-1, so requester 0 wins first.
REQ-019 Reset mid-transaction SHALL abort with no done_o pulse; requesters SHALL re-request after reset.

Configuration
REQ-020 When SCCB_ARB_TIMEOUT_EN is defined, a cycle counter SHALL run in WAIT and GAP and reset on every ISSUE.
REQ-021 With SCCB_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force start_o=0 and go to COMPLETE with err_o=1, with no retry.
REQ-022 Without SCCB_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT/GAP SHALL wait indefinitely.

Verification
REQ-023 Single write: req_i=3'b001, data 16'h1280, rw=0, controller done after 10 cycles with no error -> exactly one start_o assertion, one done_o=3'b001 pulse, err_o=0.
REQ-024 Contention: req_i=3'b111 held constantly after reset -> grant order 0,1,2,0 with one done pulse each.
REQ-025 Retry: ack_error_i=1 on the first two done edges, 0 on the third -> three start_o assertions, err_o=0; with error on all attempts -> three attempts, then err_o=1 and rdata_o=8'h00.
REQ-026 Read: rw=1, controller returns rdata_i=8'h76 -> rdata_o=8'h76 during the done_o pulse.
REQ-027 Reset at WAIT cycle 5 -> next cycle start_o=0, gnt_o=0, busy_o=0, and no done_o pulse.
REQ-028 With SCCB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, a controller that never raises done -> COMPLETE after 100 WAIT cycles, err_o=1, start_o=0.

Source files
------------

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter that shares one SCCB controller among N_REQ requesters, with NACK retry.
// Define SCCB_ARB_TIMEOUT_EN to add a WAIT/GAP watchdog limited by TIMEOUT_CYCLES.
module sccb_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ-1:0]      req_rw_i,
    input  logic [16*N_REQ-1:0]   req_data_i,
    output logic                  start_o,
    output logic                  rw_o,
    output logic [15:0]           data_o,
    input  logic                  sccb_done_i,
    input  logic                  ack_error_i,
    input  logic [7:0]            rdata_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      done_o,
    output logic                  err_o,
    output logic [7:0]            rdata_o,
    output logic                  busy_o
);
    localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StGap, StComplete} state_e;

    state_e            r_state, w_state_next;
    logic [IdxW-1:0]   r_last_grant, r_owner, w_pick;
    logic              w_pick_valid;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_rw, r_err, r_done_prev;
    logic [15:0]       r_data;
    logic [7:0]        r_rdata;
    logic [RetryW-1:0] r_retry;
    logic              w_done_edge, w_retry_left, w_timeout;

    assign w_done_edge  = sccb_done_i && !r_done_prev;
    assign w_retry_left = (r_retry < RetryW'(MAX_RETRY));

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == StIssue) begin
            r_cnt <= '0;
        end else if (r_state == StWait || r_state == StGap) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == StWait || r_state == StGap) &&
                       (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        int unsigned     v_idx;
        logic [IdxW-1:0] v_sel;
        w_pick       = '0;
        w_pick_valid = 1'b0;
        v_idx        = 0;
        v_sel        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            v_idx = (32'(r_last_grant) + 1 + i) % N_REQ;
            v_sel = IdxW'(v_idx);
            if (!w_pick_valid && req_i[v_sel]) begin
                w_pick       = v_sel;
                w_pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (w_pick_valid) w_state_next = StIssue;
            StIssue:    w_state_next = StWait;
            StWait: begin
                if (w_done_edge) begin
                    w_state_next = (ack_error_i && w_retry_left) ? StGap : StComplete;
                end else if (w_timeout) begin
                    w_state_next = StComplete;
                end
            end
            StGap: begin
                if (w_timeout) begin
                    w_state_next = StComplete;
                end else if (sccb_done_i) begin
                    w_state_next = StIssue;
                end
            end
            StComplete: w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    always_comb begin
        start_o = (r_state == StIssue) ||
                  (r_state == StWait && !w_done_edge && !w_timeout);
        done_o  = (r_state == StComplete) ? r_gnt : '0;
        busy_o  = (r_state != StIdle);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= IdxW'(N_REQ - 1);
            r_owner      <= '0;
            r_gnt        <= '0;
            r_rw         <= 1'b0;
            r_data       <= '0;
            r_retry      <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_done_prev  <= 1'b0;
        end else begin
            r_done_prev <= sccb_done_i;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick;
                        r_gnt   <= N_REQ'(1) << w_pick;
                        r_rw    <= req_rw_i[w_pick];
                        r_data  <= req_data_i[16*w_pick +: 16];
                        r_retry <= '0;
                    end
                end
                StWait: begin
                    if (w_done_edge) begin
                        if (!ack_error_i) begin
                            r_err   <= 1'b0;
                            r_rdata <= rdata_i;
                        end else if (w_retry_left) begin
                            r_retry <= r_retry + 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                StGap: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                StComplete: begin
                    r_last_grant <= r_owner;
                    r_gnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign rw_o    = r_rw;
    assign data_o  = r_data;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;

endmodule
